// File: rtl/adpll_pkg.sv
// Shared encodings and helpers for the ADPLL channel/TX sequencer and its controller.
package adpll_pkg;

  localparam int FCW_W  = 26;
  localparam int BYTE_W = 8;
  localparam int CHAN_W = 6;
  localparam logic [CHAN_W-1:0] CHAN_MAX = 6'd39;

  typedef enum logic [1:0] {
    MODE_PD   = 2'd0,
    MODE_TEST = 2'd1,
    MODE_RX   = 2'd2,
    MODE_TX   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CHAN  = 2'd1,
    ERR_LOCK  = 2'd2,
    ERR_UFLOW = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCKING,
    ST_RX_ON,
    ST_TEST_ON,
    ST_TX_GUARD,
    ST_TX_DATA
  } state_e;

  function automatic logic [FCW_W-1:0] chan_fcw(input logic [FCW_W-1:0]  base,
                                                input logic [FCW_W-1:0]  step,
                                                input logic [CHAN_W-1:0] chan);
    return base + step * FCW_W'(chan);
  endfunction

endpackage

// File: rtl/adpll_tx_ser.sv
// TX byte serialiser: one-byte holding buffer feeding an LSB-first shift register
// at one bit per SYM_CYC enabled cycles.
module adpll_tx_ser
  import adpll_pkg::*;
#(
  parameter int SYM_CYC = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tx_win_nxt,
  input  logic              start,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic              data_mod,
  output logic              buf_full,
  output logic              byte_end,
  output logic              byte_last
);

  localparam int SYM_W = $clog2(SYM_CYC + 1);
  localparam int BIT_W = $clog2(BYTE_W);

  logic [BYTE_W-1:0] buf_byte_p0;
  logic              buf_last_p0;
  logic              vld_p0;
  logic [BYTE_W-1:0] shift_p1;
  logic              last_p1;
  logic              vld_p1;
  logic [SYM_W-1:0]  sym_cnt;
  logic [BIT_W-1:0]  bit_idx;

  logic load, xfer, sym_wrap, vld_p0_nxt;

  assign load       = tx_valid & tx_ready;
  assign sym_wrap   = vld_p1 & (sym_cnt == SYM_W'(SYM_CYC - 1));
  assign byte_end   = sym_wrap & (bit_idx == BIT_W'(BYTE_W - 1));
  assign byte_last  = last_p1;
  assign buf_full   = vld_p0;
  // Back-to-back bytes move from buffer to shifter on the wrap itself, no gap cycle.
  assign xfer       = start | (byte_end & ~last_p1 & vld_p0);
  assign vld_p0_nxt = load | (vld_p0 & ~xfer);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      sym_cnt  <= '0;
      bit_idx  <= '0;
      data_mod <= 1'b0;
      tx_ready <= 1'b0;
    end else if (en) begin
      if (!tx_win_nxt) begin
        vld_p0   <= 1'b0;
        vld_p1   <= 1'b0;
        sym_cnt  <= '0;
        bit_idx  <= '0;
        data_mod <= 1'b0;
        tx_ready <= 1'b0;
      end else begin
        vld_p0   <= vld_p0_nxt;
        tx_ready <= ~vld_p0_nxt;
        if (xfer) begin
          vld_p1   <= 1'b1;
          sym_cnt  <= '0;
          bit_idx  <= '0;
          data_mod <= buf_byte_p0[0];
        end else if (sym_wrap) begin
          sym_cnt  <= '0;
          bit_idx  <= bit_idx + BIT_W'(1);
          data_mod <= shift_p1[1];
        end else if (vld_p1) begin
          sym_cnt  <= sym_cnt + SYM_W'(1);
        end
      end
    end
  end

  // Stage p0: holding buffer
  always_ff @(posedge clk) begin
    if (en && load) begin
      buf_byte_p0 <= tx_byte;
      buf_last_p0 <= tx_last;
    end
  end

  // Stage p1: shift register
  always_ff @(posedge clk) begin
    if (en) begin
      if (xfer) begin
        shift_p1 <= buf_byte_p0;
        last_p1  <= buf_last_p0;
      end else if (sym_wrap) begin
        shift_p1 <= shift_p1 >> 1;
      end
    end
  end

endmodule

// File: rtl/adpll_chan_seq.sv
// Channel/TX sequencer: turns host commands into FCW and mode for the ADPLL controller,
// supervises lock acquisition, and paces packet transmission.
module adpll_chan_seq
  import adpll_pkg::*;
#(
  parameter logic [FCW_W-1:0] FCW_BASE = 26'd1229824,
  parameter logic [FCW_W-1:0] FCW_STEP = 26'd1024,
  parameter int               SYM_CYC  = 32,
  parameter int               LOCK_TO  = 1023,
  parameter int               BLANK    = 4,
  parameter int               GUARD    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [CHAN_W-1:0] cmd_chan,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_last,
  input  logic              channel_lock,
  output logic [FCW_W-1:0]  fcw,
  output logic [1:0]        adpll_mode,
  output logic              data_mod,
  output logic              rx_on,
  output logic              tx_done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int LOCK_TW = $clog2(LOCK_TO + 1);
  localparam int GRD_W   = $clog2(GUARD + 1);

  state_e             state, state_nxt;
  logic [LOCK_TW-1:0] lock_cnt, lock_cnt_nxt;
  logic [GRD_W-1:0]   guard_cnt, guard_cnt_nxt;
  logic [FCW_W-1:0]   fcw_nxt;
  logic [1:0]         mode_nxt, err_code_nxt;
  logic               err_nxt, done_nxt, cmd_ready_nxt, rx_on_nxt, tx_win_nxt;
  logic               cmd_fire, ser_start, buf_full, byte_end, byte_last;

  assign cmd_fire = cmd_valid & cmd_ready;

  always_comb begin
    state_nxt     = state;
    lock_cnt_nxt  = lock_cnt;
    guard_cnt_nxt = guard_cnt;
    fcw_nxt       = fcw;
    mode_nxt      = adpll_mode;
    err_nxt       = 1'b0;
    err_code_nxt  = err_code;
    done_nxt      = 1'b0;
    ser_start     = 1'b0;

    case (state)
      ST_IDLE, ST_RX_ON, ST_TEST_ON: begin
        if (cmd_fire) begin
          if (cmd_chan > CHAN_MAX) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_CHAN;
          end else begin
            case (cmd_mode)
              MODE_PD: begin
                mode_nxt  = MODE_PD;
                state_nxt = ST_IDLE;
              end
              MODE_TEST: begin
                fcw_nxt   = chan_fcw(FCW_BASE, FCW_STEP, cmd_chan);
                mode_nxt  = MODE_TEST;
                state_nxt = ST_TEST_ON;
              end
              default: begin
                fcw_nxt      = chan_fcw(FCW_BASE, FCW_STEP, cmd_chan);
                mode_nxt     = cmd_mode;
                lock_cnt_nxt = '0;
                state_nxt    = ST_LOCKING;
              end
            endcase
          end
        end
      end
      ST_LOCKING: begin
        lock_cnt_nxt = lock_cnt + LOCK_TW'(1);
        // The controller's lock from the previous channel drops late, so blank it out.
        if (lock_cnt >= LOCK_TW'(BLANK) && channel_lock) begin
          guard_cnt_nxt = '0;
          state_nxt     = (adpll_mode == MODE_RX) ? ST_RX_ON : ST_TX_GUARD;
        end else if (lock_cnt == LOCK_TW'(LOCK_TO - 1)) begin
          err_nxt      = 1'b1;
          err_code_nxt = ERR_LOCK;
          mode_nxt     = MODE_PD;
          state_nxt    = ST_IDLE;
        end
      end
      ST_TX_GUARD: begin
        if (guard_cnt == GRD_W'(GUARD - 1)) begin
          if (buf_full) begin
            ser_start = 1'b1;
            state_nxt = ST_TX_DATA;
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_UFLOW;
            mode_nxt     = MODE_PD;
            state_nxt    = ST_IDLE;
          end
        end else begin
          guard_cnt_nxt = guard_cnt + GRD_W'(1);
        end
      end
      ST_TX_DATA: begin
        if (byte_end) begin
          if (byte_last) begin
            done_nxt  = 1'b1;
            mode_nxt  = MODE_PD;
            state_nxt = ST_IDLE;
          end else if (!buf_full) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_UFLOW;
            mode_nxt     = MODE_PD;
            state_nxt    = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_RX_ON) || (state_nxt == ST_TEST_ON);
    rx_on_nxt     = (state_nxt == ST_RX_ON);
    tx_win_nxt    = (state_nxt == ST_TX_GUARD) || (state_nxt == ST_TX_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      lock_cnt   <= '0;
      guard_cnt  <= '0;
      fcw        <= FCW_BASE;
      adpll_mode <= MODE_PD;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      tx_done    <= 1'b0;
      cmd_ready  <= 1'b1;
      rx_on      <= 1'b0;
    end else if (en) begin
      state      <= state_nxt;
      lock_cnt   <= lock_cnt_nxt;
      guard_cnt  <= guard_cnt_nxt;
      fcw        <= fcw_nxt;
      adpll_mode <= mode_nxt;
      err        <= err_nxt;
      err_code   <= err_code_nxt;
      tx_done    <= done_nxt;
      cmd_ready  <= cmd_ready_nxt;
      rx_on      <= rx_on_nxt;
    end
  end

  adpll_tx_ser #(
    .SYM_CYC (SYM_CYC)
  ) u_tx_ser (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tx_win_nxt (tx_win_nxt),
    .start      (ser_start),
    .tx_valid   (tx_valid),
    .tx_byte    (tx_byte),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .data_mod   (data_mod),
    .buf_full   (buf_full),
    .byte_end   (byte_end),
    .byte_last  (byte_last)
  );

endmodule

// File: doc/adpll_chan_seq.md
# adpll_chan_seq

Channel and TX-data sequencer directly upstream of the ADPLL controller. Converts a host command (mode plus BLE channel 0-39) into the controller's FCW/adpll_mode inputs, supervises channel acquisition via channel_lock with a timeout, and in TX serialises a byte stream onto data_mod at a fixed symbol rate.

## Interface
- FCW_BASE, 26'd1229824: FCW of channel 0 (2402 MHz / 32 MHz ref, 14 fractional bits)
- FCW_STEP, 26'd1024: FCW increment per channel (2 MHz)
- SYM_CYC, 32: clk cycles per symbol (1 Mb/s)
- LOCK_TO, 1023: max cycles in LOCKING before timeout
- BLANK, 4: initial LOCKING cycles in which channel_lock is ignored
- GUARD, 4: cycles from lock to first TX symbol
- clk  in  1  32 MHz reference clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  clock enable; when low all state and outputs hold
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_mode  in  2  PD=0, TEST=1, RX=2, TX=3
- cmd_chan  in  6  channel number
- tx_valid / tx_ready  in/out  1  TX byte handshake
- tx_byte  in  8  payload byte, LSB sent first
- tx_last  in  1  marks final byte, sampled with tx_byte
- channel_lock  in  1  from controller
- fcw  out  26  to controller FCW
- adpll_mode  out  2  to controller adpll_mode
- data_mod  out  1  to controller data_mod
- rx_on  out  1  high while locked in RX
- tx_done  out  1  one-cycle pulse at end of packet
- err  out  1  one-cycle pulse; err_code valid with it
- err_code  out  2  1 = bad channel, 2 = lock timeout, 3 = TX underflow

## Operation
- States: IDLE, LOCKING, RX_ON, TEST_ON, TX_GUARD, TX_DATA.
- cmd_ready = 1 in IDLE, RX_ON, TEST_ON; 0 elsewhere.
- Accepted command with cmd_chan > 39: err, err_code = 1; state and outputs unchanged.
- PD: adpll_mode <= PD, go to IDLE. TEST: fcw/adpll_mode loaded, go to TEST_ON, no lock wait.
- RX/TX: fcw <= FCW_BASE + FCW_STEP*cmd_chan, adpll_mode <= cmd_mode, go to LOCKING, clear lock counter.
- LOCKING: counter increments each enabled cycle. channel_lock is ignored while counter < BLANK, because the controller's stale lock drops late. Then channel_lock = 1 goes to RX_ON for RX, or TX_GUARD for TX. If counter reaches LOCK_TO first: err code 2, adpll_mode <= PD, go to IDLE.
- RX_ON: rx_on = 1. A new command re-tunes. channel_lock deassertion is ignored.
- TX path uses a two-stage pipeline: an 8-bit shift register plus a one-byte holding buffer.
  - tx_ready = ~buf_full in TX_GUARD and TX_DATA, else 0.
  - Load on tx_valid & tx_ready.
- TX_GUARD: data_mod = 0 for GUARD cycles. Then move buffer to shift register and enter TX_DATA. An empty buffer at that point is an underflow.
- TX_DATA:
  - data_mod = shift[0]; symbol counter runs 0..SYM_CYC-1.
  - On wrap, shift right and advance bit index.
  - After bit 7: if the byte had last set, tx_done, adpll_mode <= PD, data_mod <= 0, go to IDLE.
  - Otherwise, if the buffer is full, transfer it with no gap cycle.
  - Otherwise underflow: err code 3, adpll_mode <= PD, go to IDLE.
- Simultaneous buffer transfer and new tx handshake in the same cycle is legal; buffer stays full.

## Timing
- Reset values:
  - fcw = FCW_BASE, adpll_mode = PD, data_mod = 0.
  - cmd_ready = 1, tx_ready = 0, rx_on = 0, tx_done = 0, err = 0, err_code = 0.
  - State IDLE, buffer empty.
- All outputs are registered. A command accepted at edge N shows fcw/adpll_mode after edge N. The controller samples them on the following negedge.
- Lock detect latency: channel_lock high at edge M (M ≥ BLANK cycles into LOCKING) gives rx_on = 1, or TX_GUARD entry, after edge M.
- Each bit lasts exactly SYM_CYC cycles. An n-byte packet occupies GUARD + 8·n·SYM_CYC cycles from lock to tx_done.
- en low freezes all counters; SYM_CYC cadence is counted in enabled cycles only.
- rst mid-packet returns to reset values immediately: adpll_mode = PD, buffer cleared, no tx_done/err.

## Structure
- Shared package adpll_pkg:
  - mode constants PD/TEST/RX/TX, matching the controller's encoding;
  - FCW width 26;
  - err_code constants;
  - state encoding.
- Sub-module adpll_tx_ser: holding buffer, shift register, symbol/bit counters, last/underflow flags. The FSM owns only sequencing.

## Test plan
- Reset, then RX ch 0 → fcw = 1229824, adpll_mode = 2; drive lock at cycle 10 → rx_on = 1 after that edge.
- RX ch 39 with channel_lock already 1 → fcw = 1269760; lock ignored for first 4 cycles; rx_on rises in cycle 5.
- cmd_chan = 40 → err pulse, err_code = 1, fcw unchanged; RX with no lock → err code 2 at cycle 1023, adpll_mode = 0.
- TX ch 12, bytes 0xA5 then 0x3C (last) → data_mod sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, each 32 cycles; tx_done 516 cycles after lock; adpll_mode = 0.
- TX, second byte withheld → err code 3 at the end of byte 1, adpll_mode = 0, no tx_done.
- en low for 7 cycles mid-symbol → symbol lengthened by exactly 7 cycles; rst asserted mid-packet → all outputs at reset values.
